// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift blocks (piso_serializer and its
// receive partner shift_reg).
//   state_t   : two-state frame controller encoding
//   cnt_width : bit-counter width for a given word length
package shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // $clog2 returns 0 for a width of 1; the counter always needs at least
    // one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer. Accepts a WIDTH-bit word on a
// valid/ready handshake and emits it one bit per shift_en edge. Words
// stream back-to-back with no idle bit between frames.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   load_data    in   word to serialize
//   load_valid   in   load_data is valid
//   load_ready   out  word can be accepted this cycle (combinational)
//   shift_en     in   consumer takes the current bit on this edge
//   serial_out   out  current frame bit (registered)
//   serial_valid out  serial_out carries a frame bit
//   frame_done   out  one-cycle pulse after the last bit is taken
//   busy         out  frame in progress (same as serial_valid)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no frame; outputs low, shift_en ignored, ready for a word
// ST_SHIFT | frame in flight; counter holds index of bit on serial_out
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             svalid_q, svalid_d;
    logic             fdone_q, fdone_d;

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST) && shift_en;
    assign load_ready = (state_q == ST_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    // Shift toward the output end, zero fill. After WIDTH shifts the register
    // is all zero, so serial_out naturally reads 0 on return to idle.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        sout_d   = sout_q;
        svalid_d = svalid_q;
        fdone_d  = 1'b0;

        if (accept) begin
            // Covers both a fresh load from idle and the gapless reload on
            // the last-bit edge of the current frame.
            state_d  = ST_SHIFT;
            sreg_d   = load_data;
            cnt_d    = '0;
            sout_d   = out_bit(load_data);
            svalid_d = 1'b1;
            fdone_d  = last_bit;
        end else if ((state_q == ST_SHIFT) && shift_en) begin
            sreg_d = sreg_shifted;
            if (cnt_q == LAST) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                sout_d   = 1'b0;
                svalid_d = 1'b0;
                fdone_d  = 1'b1;
            end else begin
                cnt_d  = cnt_q + CW'(1);
                sout_d = out_bit(sreg_shifted);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            sout_q   <= 1'b0;
            svalid_q <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            sout_q   <= sout_d;
            svalid_q <= svalid_d;
            fdone_q  <= fdone_d;
        end
    end

    assign serial_out   = sout_q;
    assign serial_valid = svalid_q;
    assign frame_done   = fdone_q;
    assign busy         = svalid_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         shift_en;

    logic rdy_m, so_m, sv_m, fd_m, bz_m;
    logic rdy_l, so_l, sv_l, fd_l, bz_l;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_m), .shift_en(shift_en), .serial_out(so_m),
        .serial_valid(sv_m), .frame_done(fd_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_l), .shift_en(shift_en), .serial_out(so_l),
        .serial_valid(sv_l), .frame_done(fd_l), .busy(bz_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted word becomes W queued bits in send order.
    // The head of the queue is what must be on the wire; a shift_en edge pops
    // it; popping the last bit of a word pulses frame_done next cycle. A word
    // is accepted when nothing is queued, or when only one bit remains and
    // it is being taken on this edge. Lane 0 is MSB-first, lane 1 LSB-first.
    typedef struct packed {
        logic b;
        logic last;
    } qbit_t;

    qbit_t q[2][$];
    logic  exp_fd[2];
    bit    live = 1'b0;

    function automatic logic model_ready(input int lane);
        return (q[lane].size() == 0) || ((q[lane].size() == 1) && shift_en);
    endfunction

    always @(posedge clk) begin
        for (int lane = 0; lane < 2; lane++) begin
            if (rst) begin
                q[lane].delete();
                exp_fd[lane] = 1'b0;
            end else begin
                logic acc;
                logic popped_last;
                acc         = load_valid && model_ready(lane);
                popped_last = 1'b0;
                if ((q[lane].size() > 0) && shift_en) begin
                    popped_last = q[lane][0].last;
                    void'(q[lane].pop_front());
                end
                if (acc) begin
                    for (int i = 0; i < W; i++) begin
                        qbit_t e;
                        e.b    = (lane == 0) ? load_data[W-1-i] : load_data[i];
                        e.last = (i == W - 1);
                        q[lane].push_back(e);
                    end
                end
                exp_fd[lane] = popped_last;
            end
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_serial_out",   so_m,  (q[0].size() > 0) ? q[0][0].b : 1'b0);
            chk("m_serial_valid", sv_m,  q[0].size() > 0);
            chk("m_busy",         bz_m,  q[0].size() > 0);
            chk("m_frame_done",   fd_m,  exp_fd[0]);
            chk("m_load_ready",   rdy_m, model_ready(0));
            chk("l_serial_out",   so_l,  (q[1].size() > 0) ? q[1][0].b : 1'b0);
            chk("l_serial_valid", sv_l,  q[1].size() > 0);
            chk("l_busy",         bz_l,  q[1].size() > 0);
            chk("l_frame_done",   fd_l,  exp_fd[1]);
            chk("l_load_ready",   rdy_l, model_ready(1));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v8, v8l;
        logic [10:0] v11;
        logic [15:0] v16;
        int          fdcnt, svcnt, rdycnt;

        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h5A;
        shift_en   = 1'b1;

        // Reset held two cycles with a word offered: nothing accepted.
        for (int c = 0; c < 2; c++) begin
            step;
            chk("rst_ready", rdy_m, 1'b1);
            chk("rst_valid", sv_m, 1'b0);
            chk("rst_sout",  so_m, 1'b0);
            chk("rst_fdone", fd_m, 1'b0);
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        step;
        chk("post_rst_valid", sv_m, 1'b0);

        // Single frame 8'hA5, shift_en held.
        load_data  = 8'hA5;
        load_valid = 1'b1;
        step;
        load_valid = 1'b0;
        fdcnt = 0;
        for (int c = 1; c <= 8; c++) begin
            v8[8-c] = so_m;
            fdcnt  += int'(fd_m);
            step;
        end
        chk("a5_bits",      v8, 8'hA5);
        chk("a5_early_fd",  fdcnt, 0);
        chk("a5_fd_c9",     fd_m, 1'b1);
        chk("a5_idle_c9",   sv_m, 1'b0);
        step;
        chk("a5_fd_c10",    fd_m, 1'b0);

        // Stall: 8'hC3, shift_en low in bit cycles 3..5.
        load_data  = 8'hC3;
        load_valid = 1'b1;
        step;
        load_valid = 1'b0;
        fdcnt = 0;
        for (int c = 1; c <= 11; c++) begin
            shift_en  = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            v11[11-c] = so_m;
            fdcnt    += int'(fd_m);
            step;
        end
        chk("stall_bits",   v11, 11'b11000000011);
        chk("stall_no_fd",  fdcnt, 0);
        chk("stall_fd_c12", fd_m, 1'b1);
        step;

        // Back-to-back 8'hFF then 8'h00 with valid and shift_en held.
        load_data  = 8'hFF;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        step;
        load_data = 8'h00;
        fdcnt = 0; svcnt = 0; rdycnt = 0;
        for (int c = 1; c <= 16; c++) begin
            v16[16-c] = so_m;
            svcnt    += int'(sv_m);
            fdcnt    += int'(fd_m);
            if (c < 8) rdycnt += int'(rdy_m);
            if (c == 8) chk("b2b_ready_c8", rdy_m, 1'b1);
            if (c == 9) begin
                chk("b2b_fd_c9", fd_m, 1'b1);
                load_valid = 1'b0;
            end
            step;
        end
        chk("b2b_bits",    v16, 16'hFF00);
        chk("b2b_valid",   svcnt, 16);
        chk("b2b_fd_once", fdcnt, 1);
        chk("b2b_ready",   rdycnt, 0);
        chk("b2b_fd_end",  fd_m, 1'b1);
        step;

        // Abort after three bits, then a clean frame.
        load_data  = 8'hFF;
        load_valid = 1'b1;
        step;
        load_valid = 1'b0;
        step;
        step;
        step;
        chk("abort_busy_before", sv_m, 1'b1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_sout",  so_m, 1'b0);
        chk("abort_valid", sv_m, 1'b0);
        chk("abort_fd",    fd_m, 1'b0);
        chk("abort_busy",  bz_m, 1'b0);
        step;
        chk("abort_fd_next", fd_m, 1'b0);
        load_data  = 8'h81;
        load_valid = 1'b1;
        step;
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            v8[8-c] = so_m;
            step;
        end
        chk("after_abort_bits", v8, 8'h81);
        chk("after_abort_fd",   fd_m, 1'b1);
        step;

        // LSB-first lane with 8'h01: a single 1 then seven 0s.
        load_data  = 8'h01;
        load_valid = 1'b1;
        step;
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            v8l[8-c] = so_l;
            v8[8-c]  = so_m;
            step;
        end
        chk("lsb_bits", v8l, 8'b1000_0000);
        chk("msb_bits", v8,  8'b0000_0001);
        chk("lsb_fd",   fd_l, 1'b1);
        step;
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer: accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per `shift_en` cycle on `serial_out`. It is the transmit counterpart to the serial-in/parallel-out `shift_reg`, so its output can feed that block's `data_in` directly. Back-to-back words stream with no idle bit between frames.

## Interface
- `WIDTH`, 8, word length in bits; must be ≥ 2.
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_data`  in  WIDTH  word to serialize.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  the block can accept a word this cycle.
- `shift_en`  in  1  consumer takes the current bit on this edge.
- `serial_out`  out  1  current bit, registered.
- `serial_valid`  out  1  `serial_out` carries a frame bit.
- `frame_done`  out  1  one-cycle pulse after the last bit is taken.
- `busy`  out  1  a frame is in progress (equal to `serial_valid`).

## Operation
- States: IDLE, SHIFT.
- **Reset values:** state IDLE, shift register 0, bit counter 0, `serial_out` 0, `serial_valid` 0, `frame_done` 0, `busy` 0.
- **Ready logic (combinational):** `load_ready` = IDLE OR (SHIFT AND counter == WIDTH-1 AND `shift_en`).
- **Accept:** a word is accepted when `load_valid && load_ready`.
  - The word is captured into the shift register.
  - The counter is set to 0 and the state goes to SHIFT.
- **Bit output:** `serial_out` is the shift register MSB when `MSB_FIRST`=1, otherwise its LSB.
- **Shifting:** in SHIFT, each edge with `shift_en`=1 does three things:
  - shifts the register toward the output end, filling with 0;
  - increments the counter;
  - latches the next bit onto `serial_out`.
- **Stall:** in SHIFT with `shift_en`=0, the register, counter and `serial_out` all hold.
- **Last bit:** on the edge where counter == WIDTH-1 and `shift_en`=1:
  - `frame_done` goes to 1 for exactly the next cycle;
  - if a word is accepted on the same edge, the block stays in SHIFT, the new word's first bit appears next cycle and the counter restarts at 0;
  - otherwise the block returns to IDLE.
- **IDLE outputs:** `serial_out`=0, `serial_valid`=0. `shift_en` is ignored.
- **Load during a frame:** `load_valid` while in SHIFT and not on the last-bit edge is not accepted; the producer holds the word and `load_valid`.
- **Counter:** width $clog2(WIDTH). It never exceeds WIDTH-1, and wrap-around happens only through the accept path.
- **Reset mid-frame:** the frame is aborted. Next cycle all outputs take their reset values, and `frame_done` is not pulsed.
- **Simultaneous events:** `rst` overrides load and shift.

## Timing
- **Load-to-first-bit latency:** 1 cycle. The word is accepted at edge k, and bit 0 of the frame is on `serial_out` with `serial_valid`=1 during cycle k+1.
- **Bit hold:** each bit is stable from the edge that presents it until the edge where `shift_en`=1 takes it.
- **Frame duration:** WIDTH `shift_en` edges. With `shift_en` held high, one frame is exactly WIDTH cycles.
- **Frame end:** `frame_done` is high in the cycle after the last-bit edge, coincident with either the next frame's first bit or IDLE.
- **Gapless streaming:** with `load_valid` held, `shift_en` held and words available, `serial_valid` stays high continuously across frames.
- **Output registering:** all outputs are registered except `load_ready`.

## Structure
- Shared package `shift_pkg` holds:
  - state encodings `ST_IDLE`=1'b0 and `ST_SHIFT`=1'b1;
  - the counter-width function.
- `shift_reg` uses the same package, so the pair stays consistent.
- Single module; the counter and the shift register are inline. No sub-module.

## Test plan
All scenarios use WIDTH=8 and MSB_FIRST=1 unless stated.
1. **Reset:** `rst`=1 for 2 cycles with `load_valid`=1 -> `load_ready`=1, `serial_valid`=0, `serial_out`=0, `frame_done`=0, and no word accepted.
2. **Single frame:** load 8'hA5, `shift_en`=1 constant -> `serial_out` = 1,0,1,0,0,1,0,1 over cycles 1–8; `frame_done`=1 in cycle 9 only; IDLE in cycle 9.
3. **Stall:** load 8'hC3, drop `shift_en` for 3 cycles after bit 2 -> bit 2 (0) is held for 4 cycles; the remaining sequence is unchanged; `frame_done` is delayed by 3 cycles.
4. **Back-to-back:** 8'hFF then 8'h00 with `load_valid` and `shift_en` held -> 16 contiguous `serial_valid` cycles (eight 1s then eight 0s); `load_ready` high in the 8th bit cycle; `frame_done` pulses once between the frames.
5. **Abort:** load 8'hFF and assert `rst` after 3 bits -> next cycle shows IDLE with `serial_out`=0 and no `frame_done`; a subsequent load of 8'h81 serializes correctly.
6. **LSB-first:** `MSB_FIRST`=0, load 8'h01 -> `serial_out` is 1 then seven 0s.
